lzc_norm_pipe: RTL
==================

Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero/leading-one counter with integrated left-normalising shifter.
- Successor of the 16-bit combinational leading-one detector; generalises to power-of-two WIDTH.
- Adds per-transaction mode, configurable register placement, valid/ready backpressure and tag passthrough.
- Sits in front of FP add/mul normalisation and in the accumulator renormalise path.

Parameters:
- WIDTH, 32, data width; power of two, 4..128.
- REG_EVERY, 1, pipeline register after every REG_EVERY shift stages; the final stage is always registered.
- TAG_W, 4, width of the opaque sideband tag carried alongside the data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  operand x
- in_mode  in  1  0 = count leading zeros (find leading one); 1 = count leading ones (find leading zero)
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_cnt  out  CW = log2(WIDTH)  leading count
- out_norm  out  WIDTH  in_data << out_cnt, zero-filled
- out_all  out  1  operand had no detectable bit (all-0 in mode 0, all-1 in mode 1)
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Stages: L = log2(WIDTH) shift stages. Stage k (k = 0..L-1) tests the top 2^(L-1-k) bits of the running value against the pattern for the mode (zeros, or ones for mode 1). On a match it shifts the value left by that amount and sets count bit L-1-k. This halving search generalises the 16-bit detector.
- Mode 1 implementation: the detector operates on the inverted operand, while out_norm is built by shifting the original operand.
- Latency: LAT = ceil(L/REG_EVERY) cycles from an accepted input to out_valid. The stage holding the last shift is always registered.
- All-bits-match case: out_cnt = WIDTH-1 (saturated, all ones), out_all = 1, out_norm = in_data << (WIDTH-1). In mode 0 this gives 0. In mode 1 it gives MSB=1 and the rest 0. out_all = 0 in every other case.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - All pipeline registers (data, count, mode, tag, valid) load only when advance = 1. This is a global stall; bubbles are not collapsed.
  - A transfer occurs on in_valid & in_ready (input side) and on out_valid & out_ready (output side).
  - While out_valid = 1 and out_ready = 0, out_* are held stable and in_ready = 0.
- Throughput: one result per cycle with out_ready held high.
- Simultaneous accept and drain: allowed in the same cycle; ordering is strictly FIFO.
- Reset:
  - All stage valid bits clear. out_valid = 0, out_cnt = 0, out_norm = 0, out_all = 0, out_tag = 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards all in-flight transactions; no partial results are emitted.
- Width rules:
  - Shifts are logical left within WIDTH bits; bits shifted out are dropped.
  - out_cnt is exactly CW bits and never wraps.
- Assertion (non-synthesised): WIDTH is a power of two, and REG_EVERY is between 1 and L.

Decomposition:
- Package fp_norm_pkg:
  - mode enum LZ_MODE_ZEROS = 0, LZ_MODE_ONES = 1.
  - constant function clog2.
  - typedef for the stage bundle {valid, mode, tag, value, orig, cnt}.
- Sub-module lzc_norm_stage:
  - Combinational single stage, parametrised by WIDTH and SHIFT.
  - Test the top SHIFT bits, conditionally shift, set the count bit.
  - The top level generates L instances and inserts registers per REG_EVERY.

Test Plan:
- WIDTH=16, REG_EVERY=1, mode 0:
  - in_data=16'h0001 -> LAT=4 cycles later: out_cnt=15, out_norm=16'h8000, out_all=0.
  - 16'h00F0 -> cnt=8, norm=16'hF000.
- WIDTH=16, mode 0, in_data=16'h0000 -> cnt=15, norm=16'h0000, out_all=1. Mode 1, in_data=16'hFFFF -> cnt=15, norm=16'h8000, out_all=1.
- WIDTH=16, mode 1, in_data=16'hFC3A -> cnt=6, norm=16'h0E80, out_all=0. Mode 1, in_data=16'h7FFF -> cnt=0, norm unchanged.
- Backpressure, WIDTH=32, REG_EVERY=2 (LAT=3):
  - Stream tags 0..7 back to back; hold out_ready=0 for 5 cycles mid-stream.
  - in_ready drops while out_valid=1; outputs stay stable; all 8 results arrive in tag order with no loss or duplication.
- Reset mid-stream: with 3 transactions in flight, pulse rst for 1 cycle -> out_valid=0 the next cycle and stays 0 with no stale results; a new input produces a correct result after LAT cycles.
- Random sweep of WIDTH in {8, 16, 64} × REG_EVERY in {1, L}, 10k operands with random out_ready -> scoreboard against a reference model of the count/shift/all-flag rules.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the FP normalisation datapath.
// Mode encoding, control bundle and a constant log2.
package fp_norm_pkg;

    // Search pattern: find the leading one (count zeros) or
    // find the leading zero (count ones).
    typedef enum logic {
        LZ_MODE_ZEROS = 1'b0,
        LZ_MODE_ONES  = 1'b1
    } lz_mode_e;

    // Width-independent control part of the stage bundle.
    // The data part (tag, value, orig, cnt) depends on the
    // instance parameters and is appended by the pipeline.
    typedef struct packed {
        logic     valid;
        lz_mode_e mode;
    } lz_ctl_t;

    localparam int LZ_MIN_WIDTH = 4;
    localparam int LZ_MAX_WIDTH = 128;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lzc_norm_stage.sv
// One halving step of the leading-pattern search.
// Tests the top SHIFT bits and shifts them out on a match.
module lzc_norm_stage #(
    parameter int WIDTH = 32,
    parameter int CW    = 5,
    parameter int BIT   = 4,
    parameter int SHIFT = 16
) (
    input  logic [WIDTH-1:0] in_value,
    input  logic [WIDTH-1:0] in_orig,
    input  logic [CW-1:0]    in_cnt,
    output logic [WIDTH-1:0] out_value,
    output logic [WIDTH-1:0] out_orig,
    output logic [CW-1:0]    out_cnt
);

    logic hit;

    // The detector value is always searched for zeros; mode 1
    // inverts it on entry so orig is shifted in lock-step.
    always_comb begin
        hit       = (in_value[WIDTH-1 -: SHIFT] == '0);
        out_value = in_value;
        out_orig  = in_orig;
        out_cnt   = in_cnt;
        if (hit) begin
            out_value    = in_value << SHIFT;
            out_orig     = in_orig << SHIFT;
            out_cnt[BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading zero/one counter with left normaliser.
// Global-stall valid/ready pipeline, tag carried alongside.
module lzc_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4,
    localparam int CW       = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = CW;

    typedef struct packed {
        lz_ctl_t          ctl;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] orig;
        logic [CW-1:0]    cnt;
    } stage_t;

    stage_t head;
    stage_t tail;
    stage_t link [L+1];
    logic   advance;
    logic   all_hit;

    assign advance = ~tail.ctl.valid | out_ready;
    assign in_ready = advance;

    // Build the stage-0 bundle; mode 1 searches the inverse.
    always_comb begin
        head           = '0;
        head.ctl.valid = in_valid;
        head.ctl.mode  = lz_mode_e'(in_mode);
        head.tag       = in_tag;
        head.orig      = in_data;
        head.value     = in_mode ? ~in_data : in_data;
    end

    assign link[0] = head;

    for (genvar k = 0; k < L; k++) begin : g_st
        localparam int BIT = L - 1 - k;
        localparam int SH  = 1 << BIT;
        localparam bit REG = ((k + 1) % REG_EVERY == 0)
                          || (k == L - 1);

        stage_t           cur;
        stage_t           nxt;
        logic [WIDTH-1:0] s_value;
        logic [WIDTH-1:0] s_orig;
        logic [CW-1:0]    s_cnt;

        assign cur = link[k];

        lzc_norm_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .BIT   (BIT),
            .SHIFT (SH)
        ) u_stage (
            .in_value  (cur.value),
            .in_orig   (cur.orig),
            .in_cnt    (cur.cnt),
            .out_value (s_value),
            .out_orig  (s_orig),
            .out_cnt   (s_cnt)
        );

        // Merge the shifted data back into the bundle.
        always_comb begin
            nxt       = cur;
            nxt.value = s_value;
            nxt.orig  = s_orig;
            nxt.cnt   = s_cnt;
        end

        if (REG) begin : g_reg
            stage_t q;

            // Stage register; loads only when the pipe advances.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (advance) begin
                    q <= nxt;
                end
            end

            assign link[k+1] = q;
        end else begin : g_comb
            assign link[k+1] = nxt;
        end
    end

    assign tail = link[L];

    // A fully matched operand leaves nothing in the detector.
    assign all_hit   = ~|tail.value;
    assign out_valid = tail.ctl.valid;
    assign out_cnt   = tail.cnt;
    assign out_norm  = tail.orig;
    assign out_all   = tail.ctl.valid & all_hit;
    assign out_tag   = tail.tag;

    // Parameter sanity and the normalised-MSB invariant.
    always_ff @(posedge clk) begin
        assert (WIDTH == (1 << CW));
        assert (WIDTH >= LZ_MIN_WIDTH && WIDTH <= LZ_MAX_WIDTH);
        assert (REG_EVERY >= 1 && REG_EVERY <= L);
        if (!rst && tail.ctl.valid) begin
            assert (tail.orig[WIDTH-1] ==
                    ((tail.ctl.mode == LZ_MODE_ONES) ^ ~all_hit));
        end
    end

endmodule
